// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control state encodings and counter width.
package pipe_ctrl_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    REDIR_WAIT = 2'd1,
    DSTALL     = 2'd2,
    HALTED     = 2'd3
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, async active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + W'(1);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/bubble sequencer for the five-stage pipeline.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memRead_e,
  input  logic [2:0]       writeRegSel_e,
  input  logic [2:0]       regRs_d,
  input  logic [2:0]       regRt_d,
  input  logic             rsUsed_d,
  input  logic             rtUsed_d,
  input  logic             PCSrc,
  input  logic             instMem_stall,
  input  logic             dataMem_stall,
  input  logic             halt_m,
  output logic             pcWrite,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             fetch_hold,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stallCnt
);
  // Enable order: pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_w, fetch_hold
  localparam logic [7:0] EN_NORM   = 8'b1101_0110;
  localparam logic [7:0] EN_FREEZE = 8'b0000_0001;
  localparam logic [7:0] EN_HALT   = 8'b0111_1110;
  localparam logic [7:0] EN_REDIR  = 8'b1111_1110;
  localparam logic [7:0] EN_LU     = 8'b0001_1110;
  localparam logic [7:0] EN_IMEM   = 8'b0111_0110;
  state_t     r_state, r_ret, w_next, w_ret, w_ctx;
  logic [7:0] w_en;
  logic       w_lu, w_inc;
  always_comb begin
    w_ctx  = (r_state == DSTALL) ? r_ret : r_state;
    w_lu   = memRead_e & ((rsUsed_d & (regRs_d == writeRegSel_e)) |
                          (rtUsed_d & (regRt_d == writeRegSel_e)));
    w_en   = EN_NORM;
    w_next = RUN;
    w_ret  = r_ret;
    if (r_state == HALTED) begin
      w_en   = EN_HALT;
      w_next = HALTED;
    end else if (dataMem_stall) begin
      w_en   = EN_FREEZE;
      w_next = DSTALL;
      w_ret  = w_ctx;
    end else if (halt_m) begin
      w_en   = EN_HALT;
      w_next = HALTED;
    end else if (PCSrc) begin
      w_en   = EN_REDIR;
      w_next = (instMem_stall || w_ctx == REDIR_WAIT) ? REDIR_WAIT : RUN;
    end else begin
      // REDIR_WAIT squashes the stale fetch up to and including its completing cycle
      w_en   = w_lu ? EN_LU : (instMem_stall || w_ctx == REDIR_WAIT) ? EN_IMEM : EN_NORM;
      w_next = (instMem_stall && w_ctx == REDIR_WAIT) ? REDIR_WAIT : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_ret   <= RUN;
    end else begin
      r_state <= w_next;
      r_ret   <= w_ret;
    end
  assign {pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble,
          exmem_write, memwb_write, fetch_hold} = rst_n ? w_en : 8'h00;
  assign ctrl_state = r_state;
  assign w_inc      = ~w_en[7] & (r_state != HALTED);
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_inc),
    .o_cnt (stallCnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;
  localparam logic [7:0] N = 8'b1101_0110;
  localparam logic [7:0] F = 8'b0000_0001;
  localparam logic [7:0] H = 8'b0111_1110;
  localparam logic [7:0] R = 8'b1111_1110;
  localparam logic [7:0] L = 8'b0001_1110;
  localparam logic [7:0] I = 8'b0111_0110;
  typedef struct packed {
    logic [7:0]  en;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic memRead_e = 0, rsUsed_d = 0, rtUsed_d = 0;
  logic [2:0] writeRegSel_e = 0, regRs_d = 0, regRt_d = 0;
  logic PCSrc = 0, instMem_stall = 0, dataMem_stall = 0, halt_m = 0;
  logic pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_write, fetch_hold;
  logic [1:0] ctrl_state;
  logic [15:0] stallCnt;
  logic p4, iw4, if4, dw4, db4, ew4, mw4, fh4;
  logic [1:0] st4;
  logic [3:0] cnt4;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .memRead_e(memRead_e), .writeRegSel_e(writeRegSel_e),
    .regRs_d(regRs_d), .regRt_d(regRt_d), .rsUsed_d(rsUsed_d), .rtUsed_d(rtUsed_d),
    .PCSrc(PCSrc), .instMem_stall(instMem_stall), .dataMem_stall(dataMem_stall), .halt_m(halt_m),
    .pcWrite(pcWrite), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .exmem_write(exmem_write), .memwb_write(memwb_write),
    .fetch_hold(fetch_hold), .ctrl_state(ctrl_state), .stallCnt(stallCnt)
  );
  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .memRead_e(memRead_e), .writeRegSel_e(writeRegSel_e),
    .regRs_d(regRs_d), .regRt_d(regRt_d), .rsUsed_d(rsUsed_d), .rtUsed_d(rtUsed_d),
    .PCSrc(PCSrc), .instMem_stall(instMem_stall), .dataMem_stall(dataMem_stall), .halt_m(halt_m),
    .pcWrite(p4), .ifid_write(iw4), .ifid_flush(if4), .idex_write(dw4),
    .idex_bubble(db4), .exmem_write(ew4), .memwb_write(mw4),
    .fetch_hold(fh4), .ctrl_state(st4), .stallCnt(cnt4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("enables", 32'({pcWrite, ifid_write, ifid_flush, idex_write, idex_bubble,
                          exmem_write, memwb_write, fetch_hold}), 32'(e.en));
      chk("ctrl_state", 32'(ctrl_state), 32'(e.st));
      chk("stallCnt", 32'(stallCnt), 32'(e.cnt));
      chk("enables_w4", 32'({p4, iw4, if4, dw4, db4, ew4, mw4, fh4}), 32'(e.en));
      chk("stallCnt_w4", 32'(cnt4), 32'(e.cnt4));
    end
  task automatic cyc(input int lu, input bit pcs, input bit im, input bit dm, input bit hm,
                     input bit rn, input logic [7:0] en, input logic [1:0] st, input int cnt);
    @(posedge clk);
    #1;
    rst_n = rn; PCSrc = pcs; instMem_stall = im; dataMem_stall = dm; halt_m = hm;
    rsUsed_d = 1; rtUsed_d = 1;
    case (lu)
      1: begin memRead_e = 1; writeRegSel_e = 3; regRs_d = 5; regRt_d = 3; end
      2: begin memRead_e = 1; writeRegSel_e = 6; regRs_d = 6; regRt_d = 1; end
      3: begin memRead_e = 1; writeRegSel_e = 4; regRs_d = 4; regRt_d = 4; rsUsed_d = 0; rtUsed_d = 0; end
      4: begin memRead_e = 0; writeRegSel_e = 2; regRs_d = 2; regRt_d = 2; end
      default: begin memRead_e = 0; writeRegSel_e = 0; regRs_d = 1; regRt_d = 2; end
    endcase
    q.push_back('{en, st, 16'(cnt), (cnt > 15) ? 4'd15 : 4'(cnt)});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
  initial begin
    //        lu pc im dm hm rn  en  st cnt
    cyc(0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, L, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 1);
    cyc(2, 0, 0, 0, 0, 1, L, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 2);
    cyc(3, 0, 0, 0, 0, 1, N, 0, 2);
    cyc(4, 0, 0, 0, 0, 1, N, 0, 2);
    cyc(0, 1, 1, 0, 0, 1, R, 0, 2);
    cyc(0, 0, 1, 0, 0, 1, I, 1, 2);
    cyc(0, 0, 1, 0, 0, 1, I, 1, 3);
    cyc(0, 0, 1, 0, 0, 1, I, 1, 4);
    cyc(0, 0, 0, 0, 0, 1, I, 1, 5);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 6);
    cyc(0, 0, 1, 0, 0, 1, I, 0, 6);
    cyc(0, 1, 0, 0, 0, 1, R, 0, 7);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 7);
    cyc(1, 0, 0, 1, 0, 1, F, 0, 7);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 0, 1, F, 2, 8 + k);
    cyc(1, 0, 0, 0, 0, 1, L, 2, 12);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 13);
    cyc(0, 1, 1, 0, 0, 1, R, 0, 13);
    cyc(0, 0, 1, 1, 0, 1, F, 1, 13);
    cyc(0, 0, 1, 1, 0, 1, F, 2, 14);
    cyc(0, 0, 1, 0, 0, 1, I, 2, 15);
    cyc(0, 0, 0, 0, 0, 1, I, 1, 16);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 17);
    cyc(0, 1, 1, 0, 0, 1, R, 0, 17);
    cyc(0, 0, 1, 0, 0, 1, I, 1, 17);
    cyc(0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 0);
    for (int k = 0; k < 20; k++) cyc(0, 0, 1, 0, 0, 1, I, 0, k);
    cyc(0, 0, 0, 0, 0, 1, N, 0, 20);
    cyc(0, 1, 0, 0, 1, 1, H, 0, 20);
    cyc(0, 0, 0, 0, 0, 1, H, 3, 21);
    cyc(1, 1, 1, 1, 0, 1, H, 3, 21);
    cyc(0, 0, 0, 0, 0, 1, H, 3, 21);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
